// File: rtl/cpu_ctrl_v2.sv
// Instruction sequencing controller: fetch, decode, ALU/load/store/branch sequencing
// with a bounded memory wait and absorbing HALT/ERR states.
module cpu_ctrl_v2 #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ir,
    input  logic              N,
    input  logic              V,
    input  logic              Z,
    input  logic [15:0]       dp_out,
    input  logic [ADDR_W-1:0] rd_val,
    input  logic              mem_ready,
    output logic [2:0]        nsel,
    output logic [1:0]        vsel,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic              load_ir,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              err
);
    // state | meaning
    // RST   | reset holding state
    // IF    | instruction fetch, waits for mem_ready
    // UPDPC | pc increment
    // DECODE| opcode dispatch
    // GETA/GETB/ALU/WRREG | register-register ALU path
    // MOVI  | immediate write
    // LDA/LDC/LDM/LDW | load: base, address, read, writeback
    // STA/STC/STB/STM | store: base, address, data, write
    // BR    | conditional branch or BX
    // HALT/ERR | absorbing stop / fault
    typedef enum logic [4:0] {
        S_RST, S_IF, S_UPDPC, S_DECODE, S_GETA, S_GETB, S_ALU, S_WRREG, S_MOVI,
        S_LDA, S_LDC, S_LDM, S_LDW, S_STA, S_STC, S_STB, S_STM, S_BR, S_HALT, S_ERR
    } state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t            state, next;
    logic [ADDR_W-1:0] data_addr;
    logic [CW-1:0]     wait_cnt;
    logic              addr_sel, timed_out, taken, mem_wait, next_wait;
    logic [2:0]        opcode, cond;
    logic [1:0]        op;
    logic [15:0]       imm_sx;
    logic              dp_unused;

    assign opcode    = ir[15:13];
    assign op        = ir[12:11];
    assign cond      = ir[10:8];
    assign imm_sx    = {{8{ir[7]}}, ir[7:0]};
    assign dp_unused = ^dp_out;
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT));
    assign mem_wait  = (state == S_IF) || (state == S_LDM) || (state == S_STM);
    assign next_wait = (next == S_IF) || (next == S_LDM) || (next == S_STM);

    always_comb begin
        case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = Z;
            3'b010:  taken = !Z;
            3'b011:  taken = (N != V);
            3'b100:  taken = (N != V) || Z;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next     = state;
        nsel     = 3'b000;
        vsel     = 2'b00;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        mem_cmd  = 2'b00;
        addr_sel = 1'b0;
        case (state)
            S_RST: next = S_IF;
            S_IF: begin
                mem_cmd  = 2'b01;
                addr_sel = 1'b1;
                if (mem_ready)      next = S_UPDPC;
                else if (timed_out) next = S_ERR;
            end
            S_UPDPC: next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    3'b110:  next = (op == 2'b10) ? S_MOVI : (op == 2'b00) ? S_GETB : S_ERR;
                    3'b101:  next = S_GETA;
                    3'b011:  next = S_LDA;
                    3'b100:  next = S_STA;
                    3'b001:  next = S_BR;
                    3'b010:  next = (op == 2'b11) ? S_BR : S_ERR;
                    3'b111:  next = S_HALT;
                    default: next = S_ERR;
                endcase
            end
            S_GETA: begin nsel = 3'b100; loada = 1'b1; next = S_GETB; end
            S_GETB: begin nsel = 3'b001; loadb = 1'b1; next = S_ALU; end
            S_ALU: begin
                loadc = 1'b1;
                loads = 1'b1;
                asel  = (op == 2'b11) || (opcode == 3'b110);
                next  = S_WRREG;
            end
            S_WRREG: begin
                nsel  = 3'b010;
                vsel  = 2'b11;
                write = !((opcode == 3'b101) && (op == 2'b01));
                next  = S_IF;
            end
            S_MOVI: begin nsel = 3'b100; vsel = 2'b01; write = 1'b1; next = S_IF; end
            S_LDA:  begin loada = 1'b1; next = S_LDC; end
            S_LDC:  begin bsel = 1'b1; loadc = 1'b1; next = S_LDM; end
            S_LDM: begin
                mem_cmd = 2'b01;
                if (mem_ready)      next = S_LDW;
                else if (timed_out) next = S_ERR;
            end
            S_LDW:  begin nsel = 3'b010; vsel = 2'b00; write = 1'b1; next = S_IF; end
            S_STA:  begin loada = 1'b1; next = S_STC; end
            S_STC:  begin bsel = 1'b1; loadc = 1'b1; next = S_STB; end
            S_STB:  begin nsel = 3'b010; loadb = 1'b1; next = S_STM; end
            // C follows B (store data) while the write is held
            S_STM: begin
                mem_cmd = 2'b10;
                asel    = 1'b1;
                loadc   = 1'b1;
                if (mem_ready)      next = S_IF;
                else if (timed_out) next = S_ERR;
            end
            S_BR:    next = S_IF;
            S_HALT:  next = S_HALT;
            S_ERR:   next = S_ERR;
            default: next = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RST;
            pc        <= '0;
            data_addr <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= next;
            if (state == S_UPDPC)
                pc <= pc + ADDR_W'(1);
            else if (state == S_BR) begin
                if (opcode == 3'b010) pc <= rd_val;
                else if (taken)       pc <= pc + imm_sx[ADDR_W-1:0];
            end
            if ((state == S_LDM) || (state == S_STB))
                data_addr <= dp_out[ADDR_W-1:0];
            if (next_wait && (next != state))
                wait_cnt <= '0;
            else if (mem_wait && !mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign load_ir  = (state == S_IF) && mem_ready;
    assign mem_addr = addr_sel ? pc : data_addr;
    assign halted   = (state == S_HALT);
    assign err      = (state == S_ERR);

endmodule

// File: tb/tb_cpu_ctrl_v2.sv
// Bench for cpu_ctrl_v2: per-instruction vector table with scoreboard queue, plus
// hand sequences for fetch stall, timeout, branch wrap and reset during store.
module tb_cpu_ctrl_v2;
    logic        clk = 1'b0;
    logic        reset = 1'b1, reset2 = 1'b1;
    logic [15:0] ir = 16'h0, dp_out = 16'h0042;
    logic        n_f = 1'b0, v_f = 1'b0, z_f = 1'b0;
    logic [8:0]  rd_val = 9'h0;
    logic        mem_ready = 1'b0, mem_ready2 = 1'b0;

    logic [2:0] nsel, nsel2;
    logic [1:0] vsel, vsel2, mem_cmd, mem_cmd2;
    logic       write, loada, loadb, loadc, loads, asel, bsel, load_ir, halted, err;
    logic       write2, loada2, loadb2, loadc2, loads2, asel2, bsel2, load_ir2, halted2, err2;
    logic [8:0] mem_addr, pc, mem_addr2, pc2;

    always #5 clk = ~clk;

    cpu_ctrl_v2 #(.ADDR_W(9), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .ir(ir), .N(n_f), .V(v_f), .Z(z_f), .dp_out(dp_out),
        .rd_val(rd_val), .mem_ready(mem_ready), .nsel(nsel), .vsel(vsel), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .load_ir(load_ir), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .pc(pc),
        .halted(halted), .err(err));

    cpu_ctrl_v2 #(.ADDR_W(9), .TIMEOUT(2)) dut2 (
        .clk(clk), .reset(reset2), .ir(ir), .N(n_f), .V(v_f), .Z(z_f), .dp_out(dp_out),
        .rd_val(rd_val), .mem_ready(mem_ready2), .nsel(nsel2), .vsel(vsel2), .write(write2),
        .loada(loada2), .loadb(loadb2), .loadc(loadc2), .loads(loads2), .asel(asel2),
        .bsel(bsel2), .load_ir(load_ir2), .mem_cmd(mem_cmd2), .mem_addr(mem_addr2), .pc(pc2),
        .halted(halted2), .err(err2));

    typedef struct {
        logic [15:0] ir;
        logic        n, v, z;
        logic [8:0]  rd;
        int          cycles;   // edges after leaving RST until next IF / HALT / ERR
        logic [8:0]  pc;
        int          term;     // 0 back in IF, 1 halted, 2 err
        int          writes;
        logic [1:0]  vsel;
        int          loads;
        int          stores;
        int          asels;
    } vec_t;

    vec_t vecs[20];
    vec_t exp_q[$];
    int   n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] strobes();
        return {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, load_ir, mem_cmd};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_pc", {23'd0, pc}, 32'd0);
        check("rst_strobes", {16'd0, strobes()}, 32'd0);
        check("rst_status", {30'd0, halted, err}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v, e;
        int k, lir, term, wr, ld, st, as;
        logic [1:0] wv;
        v = vecs[idx];
        ir = v.ir; n_f = v.n; v_f = v.v; z_f = v.z; rd_val = v.rd;
        mem_ready = 1'b1;
        do_reset();
        exp_q.push_back(v);
        lir = 0; term = 3; wr = 0; ld = 0; st = 0; as = 0; wv = 2'b00; k = 0;
        while (term == 3 && k < 40) begin
            tick();
            k++;
            if (load_ir) lir++;
            if (lir == 2) term = 0;
            else if (halted) term = 1;
            else if (err) term = 2;
            if (write) begin wr++; wv = vsel; end
            if (loads) ld++;
            if (mem_cmd == 2'b10) st++;
            if (asel) as++;
        end
        e = exp_q.pop_front();
        check($sformatf("v%0d_term", idx), term, e.term);
        check($sformatf("v%0d_cycles", idx), k - 1, e.cycles);
        check($sformatf("v%0d_pc", idx), {23'd0, pc}, {23'd0, e.pc});
        check($sformatf("v%0d_writes", idx), wr, e.writes);
        if (e.writes > 0) check($sformatf("v%0d_vsel", idx), {30'd0, wv}, {30'd0, e.vsel});
        check($sformatf("v%0d_loads", idx), ld, e.loads);
        check($sformatf("v%0d_stores", idx), st, e.stores);
        check($sformatf("v%0d_asel", idx), as, e.asels);
        if (e.term != 0) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                check($sformatf("v%0d_absorb_strobes", idx), {16'd0, strobes()}, 32'd0);
                check($sformatf("v%0d_absorb_status", idx), {30'd0, halted, err},
                      (e.term == 1) ? 32'd2 : 32'd1);
            end
        end
    endtask

    initial begin
        //           ir        n     v     z     rd     cyc pc      t  wr vs     ld st as
        vecs[0]  = '{16'hD005, 1'b0, 1'b0, 1'b0, 9'h0,   4, 9'h001, 0, 1, 2'b01, 0, 0, 0};
        vecs[1]  = '{16'hA148, 1'b0, 1'b0, 1'b0, 9'h0,   7, 9'h001, 0, 1, 2'b11, 1, 0, 0};
        vecs[2]  = '{16'hA920, 1'b0, 1'b0, 1'b0, 9'h0,   7, 9'h001, 0, 0, 2'b00, 1, 0, 0};
        vecs[3]  = '{16'hC041, 1'b0, 1'b0, 1'b0, 9'h0,   6, 9'h001, 0, 1, 2'b11, 1, 0, 1};
        vecs[4]  = '{16'hB802, 1'b0, 1'b0, 1'b0, 9'h0,   7, 9'h001, 0, 1, 2'b11, 1, 0, 1};
        vecs[5]  = '{16'h6105, 1'b0, 1'b0, 1'b0, 9'h0,   7, 9'h001, 0, 1, 2'b00, 0, 0, 0};
        vecs[6]  = '{16'h8203, 1'b0, 1'b0, 1'b0, 9'h0,   7, 9'h001, 0, 0, 2'b00, 0, 1, 1};
        vecs[7]  = '{16'h21FE, 1'b0, 1'b0, 1'b1, 9'h0,   4, 9'h1FF, 0, 0, 2'b00, 0, 0, 0};
        vecs[8]  = '{16'h21FE, 1'b0, 1'b0, 1'b0, 9'h0,   4, 9'h001, 0, 0, 2'b00, 0, 0, 0};
        vecs[9]  = '{16'h2010, 1'b0, 1'b0, 1'b0, 9'h0,   4, 9'h011, 0, 0, 2'b00, 0, 0, 0};
        vecs[10] = '{16'h2303, 1'b1, 1'b0, 1'b0, 9'h0,   4, 9'h004, 0, 0, 2'b00, 0, 0, 0};
        vecs[11] = '{16'h2403, 1'b0, 1'b0, 1'b0, 9'h0,   4, 9'h001, 0, 0, 2'b00, 0, 0, 0};
        vecs[12] = '{16'h2503, 1'b0, 1'b0, 1'b1, 9'h0,   4, 9'h001, 0, 0, 2'b00, 0, 0, 0};
        vecs[13] = '{16'h2205, 1'b0, 1'b0, 1'b0, 9'h0,   4, 9'h006, 0, 0, 2'b00, 0, 0, 0};
        vecs[14] = '{16'h5800, 1'b0, 1'b0, 1'b0, 9'h123, 4, 9'h123, 0, 0, 2'b00, 0, 0, 0};
        vecs[15] = '{16'hE000, 1'b0, 1'b0, 1'b0, 9'h0,   3, 9'h001, 1, 0, 2'b00, 0, 0, 0};
        vecs[16] = '{16'h0000, 1'b0, 1'b0, 1'b0, 9'h0,   3, 9'h001, 2, 0, 2'b00, 0, 0, 0};
        vecs[17] = '{16'h4000, 1'b0, 1'b0, 1'b0, 9'h0,   3, 9'h001, 2, 0, 2'b00, 0, 0, 0};
        vecs[18] = '{16'hC800, 1'b0, 1'b0, 1'b0, 9'h0,   3, 9'h001, 2, 0, 2'b00, 0, 0, 0};
        vecs[19] = '{16'h2403, 1'b0, 1'b0, 1'b1, 9'h0,   4, 9'h004, 0, 0, 2'b00, 0, 0, 0};

        tick();
        for (int i = 0; i < 20; i++) run_vec(i);

        // Fetch stalled three cycles, then completes
        begin
            int pulses;
            ir = 16'hD005;
            mem_ready = 1'b0;
            do_reset();
            pulses = 0;
            for (int j = 0; j < 3; j++) begin
                tick();
                check("stall_mem_cmd", {30'd0, mem_cmd}, 32'd1);
                check("stall_pc", {23'd0, pc}, 32'd0);
                if (load_ir) pulses++;
            end
            mem_ready = 1'b1;
            #1;
            if (load_ir) pulses++;
            tick();
            if (load_ir) pulses++;
            check("stall_updpc_pc", {23'd0, pc}, 32'd0);
            tick();
            if (load_ir) pulses++;
            check("stall_decode_pc", {23'd0, pc}, 32'd1);
            check("stall_load_ir_pulses", pulses, 1);
        end

        // TIMEOUT=2 instance: fetch never completes
        reset2 = 1'b0;
        mem_ready2 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("to_if_cmd", {30'd0, mem_cmd2}, 32'd1);
            check("to_if_err", {31'd0, err2}, 32'd0);
        end
        tick();
        check("to_err", {31'd0, err2}, 32'd1);
        check("to_err_cmd", {30'd0, mem_cmd2}, 32'd0);
        tick();
        check("to_err_hold", {31'd0, err2}, 32'd1);
        reset2 = 1'b1;
        tick();
        check("to_rst_err", {31'd0, err2}, 32'd0);
        check("to_rst_cmd", {30'd0, mem_cmd2}, 32'd0);
        reset2 = 1'b0;
        // mem_ready arriving on the terminal-count cycle wins over the timeout
        for (int j = 0; j < 3; j++) tick();
        mem_ready2 = 1'b1;
        #1;
        check("to_edge_load_ir", {31'd0, load_ir2}, 32'd1);
        tick();
        check("to_edge_no_err", {31'd0, err2}, 32'd0);
        tick();
        check("to_edge_pc", {23'd0, pc2}, 32'd1);
        reset2 = 1'b1;
        tick();
        check("to_edge_rst_pc", {23'd0, pc2}, 32'd0);

        // Store held in STM, then reset mid-access
        ir = 16'h8203;
        dp_out = 16'h0042;
        mem_ready = 1'b1;
        do_reset();
        tick();
        tick();
        mem_ready = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        check("stm_cmd", {30'd0, mem_cmd}, 32'd2);
        check("stm_addr", {23'd0, mem_addr}, 32'h42);
        tick();
        check("stm_cmd_held", {30'd0, mem_cmd}, 32'd2);
        reset = 1'b1;
        tick();
        check("stm_rst_cmd", {30'd0, mem_cmd}, 32'd0);
        check("stm_rst_pc", {23'd0, pc}, 32'd0);
        reset = 1'b0;

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl_v2.md
CPU_CTRL_V2 -- requirements
Module: cpu_ctrl_v2

Interface
REQ-001 Parameter ADDR_W, default 9: memory address and PC width, range 4..16.
REQ-002 Parameter TIMEOUT, default 15: maximum wait cycles per memory access; 0 disables the timeout.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ir  in  16  instruction register contents: opcode ir[15:13], op ir[12:11], cond ir[10:8], imm8 ir[7:0].
REQ-006 N, V, Z  in  1 each  status flags from the datapath.
REQ-007 dp_out  in  16  datapath result; low ADDR_W bits form the data address.
REQ-008 rd_val  in  ADDR_W  register value used as the BX target.
REQ-009 mem_ready  in  1  memory completes the current read or write this cycle.
REQ-010 nsel 3, vsel 2, write, loada, loadb, loadc, loads, asel, bsel: out, datapath controls.
REQ-011 load_ir  out  1  capture mdata into ir.
REQ-012 mem_cmd  out  2  00 none, 01 read, 10 write.
REQ-013 mem_addr  out  ADDR_W  equals pc when addr_sel=1, otherwise data_addr.
REQ-014 pc  out  ADDR_W  program counter.
REQ-015 halted, err  out  1 each  halt status and memory-timeout status.

Function
REQ-016 Outputs SHALL be Moore outputs decoded from the registered state; load_ir is the only exception and is gated by mem_ready.
REQ-017 States SHALL be: RST, IF, UPDPC, DECODE, GETA, GETB, ALU, WRREG, MOVI, LDA, LDC, LDM, LDW, STA, STC, STB, STM, BR, HALT, ERR.
REQ-018 RST SHALL go to IF.
REQ-019 IF SHALL drive mem_cmd=01 and addr_sel=1.
REQ-020 In IF with mem_ready=1: load_ir=1 and next state UPDPC; with mem_ready=0: stay in IF.
REQ-021 UPDPC: pc <= pc+1, modulo 2^ADDR_W; next state DECODE.
REQ-022 DECODE dispatch by opcode:
- 110 with op=10: MOVI.
- 110 with op=00: GETB.
- 101: GETA.
- 011: LDA.
- 100: STA.
- 001: BR.
- 010 with op=11: BR (BX).
- 111: HALT.
- Any other opcode: ERR.
REQ-023 ALU path: GETA (nsel=100, loada) then GETB (nsel=001, loadb) then ALU (loadc, loads; asel=1 for op 11 and for MOV) then WRREG (nsel=010, vsel=11).
REQ-024 WRREG SHALL assert write except for CMP (opcode 101, op 01); next state IF.
REQ-025 MOVI: nsel=100, vsel=01, write; next state IF.
REQ-026 LDR sequence:
- LDA: loada.
- LDC: bsel, loadc.
- LDM: data_addr <= dp_out; mem_cmd=01, addr_sel=0 held until mem_ready.
- LDW: nsel=010, vsel=00, write.
- Then IF.
REQ-027 STR sequence:
- STA: loada.
- STC: bsel, loadc.
- STB: data_addr <= dp_out; nsel=010, loadb.
- Then asel, loadc.
- STM: mem_cmd=10, addr_sel=0 held until mem_ready.
- Then IF.
REQ-028 BR conditions by cond: 000 always, 001 Z, 010 !Z, 011 N!=V, 100 (N!=V)|Z; others never taken.
REQ-029 Taken branch: pc <= pc + sign-extended imm8, truncated to ADDR_W bits.
REQ-030 BX SHALL set pc <= rd_val.
REQ-031 Not-taken branch SHALL leave pc unchanged; BR always goes to IF.
REQ-032 The wait counter SHALL clear on entry to IF, LDM or STM, and increment on each cycle in those states with mem_ready=0.
REQ-033 When the wait counter equals TIMEOUT (TIMEOUT != 0) with mem_ready=0, the next state SHALL be ERR; mem_ready=1 in that same cycle wins.
REQ-034 HALT and ERR SHALL be absorbing with all strobes 0; halted=1 in HALT, err=1 in ERR.

Reset
REQ-035 reset=1 on a clock edge SHALL force state RST, pc=0, data_addr=0 and wait counter=0, from any state, including mid-memory-access, HALT and ERR.
REQ-036 While in RST, all strobes and mem_cmd SHALL be 0, and halted and err SHALL be 0.

Verification
REQ-037 Reset, then mem_ready=1 always, MOVI R0,#5 at address 0: fetch takes 1 cycle, UPDPC gives pc=1, write with vsel=01, back in IF 4 cycles after leaving RST.
REQ-038 Fetch with mem_ready held low for 3 cycles: mem_cmd=01 stays stable, pc unchanged, load_ir pulses exactly once.
REQ-039 TIMEOUT=2 and mem_ready always 0: ERR entered after 3 IF cycles, err=1; a subsequent reset returns to RST with pc=0.
REQ-040 BEQ, imm8=0xFE, ADDR_W=9:
- From pc=0x000 after UPDPC (pc=1) with Z=1: pc becomes 0x1FF (wrap-around).
- Same instruction with Z=0: pc stays 1.
REQ-041 STR with dp_out=0x0042: in STM, mem_addr=0x042 and mem_cmd=10; reset asserted in STM gives mem_cmd=00 on the next cycle.
REQ-042 CMP in WRREG: write=0 while loads was asserted in ALU; HALT opcode gives halted=1 and no further mem_cmd.
